clk_div_multi: RTL
==================

Name: clk_div_multi

Overview:
- Multi-channel, runtime-programmable clock-enable/clock divider for the processor board.
- Each channel divides clkIn by a programmable half-period and outputs two signals:
  - a registered square wave (clkOut), for LEDs and slow stepping;
  - a one-cycle tick strobe, for synchronous logic.
- Divisors are rewritten through a single-write/ack port.
- A new divisor takes effect glitch-free, at the channel's next terminal count.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- CNT_W, 26, width of each channel's counter and divisor.
- DEF_DIV, 25000000, reset half-period for every channel, in clkIn cycles. At 50 MHz this gives 1 Hz square, 2 Hz tick.
- CH_W, derived = max(1, clog2(NUM_CH)), width of the channel select. Localparam, not overridable.

Ports:
- clkIn  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  NUM_CH  per-channel run enable.
- mode  in  NUM_CH  per-channel output mode: 0 = square on clkOut; 1 = clkOut mirrors tick.
- div_wr  in  1  divisor write strobe, sampled each cycle.
- div_ch  in  CH_W  channel addressed by the write.
- div_val  in  CNT_W  new half-period in cycles; 0 is treated as 1.
- div_ack  out  1  one-cycle acknowledge, the cycle after div_wr.
- clkOut  out  NUM_CH  divided clock per channel, registered.
- tick  out  NUM_CH  one-cycle strobe at each terminal count, registered.

Behaviour:
- Reset (rst=1 at an edge), for all channels:
  - cnt=0, div=DEF_DIV, pending=0;
  - clkOut=0, tick=0, div_ack=0.
  - rst overrides a same-cycle div_wr; that write is lost and not acked.
- Counting, per channel, while en=1:
  - If cnt == div-1 (terminal), next cnt=0. Otherwise cnt+1.
  - tick=1 in the cycle after a terminal cycle, else 0. A channel ticks once every div cycles.
  - mode=0: clkOut toggles on each terminal count, giving period 2*div cycles at 50% duty.
  - mode=1: clkOut equals tick.
- Disabled channel (en=0):
  - cnt held at 0, tick=0, clkOut forced to 0 on the next edge.
  - On re-enable the first terminal count occurs div cycles later.
- Effective divisor:
  - div_val=0 is stored as 1.
  - With div=1, tick is continuously 1 and mode-0 clkOut = clkIn/2.
- Write handshake:
  - div_wr=1 at an edge latches div_val into the addressed channel's shadow register and sets its pending flag.
  - div_ack=1 on the following cycle only.
  - Back-to-back writes are legal and are acked one-for-one.
  - A second write to a channel with pending set overwrites the shadow; last write wins.
  - div_ch >= NUM_CH: the write is acked with no effect.
- Applying a pending divisor:
  - At the channel's terminal cycle: div<=shadow, pending<=0. The new half-period starts from cnt=0, so no runt or stretched phase beyond the old half-period.
  - If en=0: applied on the next edge.
  - A write coinciding with a terminal cycle on the same channel is not applied in that cycle. It is applied at the following terminal count.
- Changing mode mid-run:
  - Takes effect next edge.
  - mode 1->0: clkOut restarts from 0 and then toggles at terminal counts.
- Arithmetic:
  - Compare against div-1 computed in CNT_W bits.
  - cnt never exceeds div-1, because div only changes at cnt=0 boundaries.

Decomposition:
- Shared package clk_div_pkg:
  - CNT_W default;
  - mode encodings MODE_SQUARE=0 and MODE_TICK=1;
  - a clog2 constant function.
- Sub-module clk_div_chan, one instance per channel via generate:
  - holds cnt, div, shadow, pending, clkOut and tick;
  - inputs: en, mode, load strobe, load value.
- Top level (write decode and div_ack): address decode, div_val zero-fix, div_ack register.

Test Plan:
- Reset, then en=4'b0001, mode=0, bench DEF_DIV=5 -> ch0:
  - clkOut rises 5 cycles after en, period 10, 50% duty;
  - tick pulses every 5 cycles;
  - ch1..3: clkOut=0, tick=0.
- Write div_ch=0, div_val=3 while ch0 is mid-half-period at cnt=2 of 5 -> div_ack the next cycle; current half-period completes at 5; subsequent half-periods are 3; no runt pulse.
- Two writes to ch1 on consecutive cycles, div_val=7 then 2, ch1 running -> two acks; ch1 adopts 2 at its next terminal count; 7 is never used.
- div_val=0 on ch2, mode=1, en=1 -> tick and clkOut held high every cycle after the apply; mode=0 -> clkOut toggles every cycle.
- rst pulsed for 1 cycle mid-count with div_wr=1 in the same cycle -> all outputs 0 the next cycle, div_ack=0, divisors back to DEF_DIV, write discarded.
- en dropped on ch3 for 4 cycles, then raised -> clkOut=0 and tick=0 during the gap; first tick exactly div cycles after re-enable; a divisor written while disabled is applied before re-enable.

Source files
------------

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants, output mode encodings and a clog2 helper for the clock divider.
package clk_div_pkg;
    localparam int CNT_W_DEF = 26;
    localparam logic MODE_SQUARE = 1'b0;
    localparam logic MODE_TICK = 1'b1;
    function automatic int clog2(input int v);
        for (int r = 0; r < 31; r++)
            if ((1 << r) >= v) return r;
        return 31;
    endfunction
endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel with a shadowed divisor that is applied at terminal count.
// Ports: clk/rst clock and sync reset; en run enable; mode square or tick output;
// load/load_val shadow write (value already zero-fixed); clk_out divided clock; tick strobe.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DEF_DIV = 25000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             clk_out,
    output logic             tick
);
    logic [CNT_W-1:0] cnt, div, shadow;
    logic pending, mode_q, term, apply;
    assign term = en && (cnt == div - CNT_W'(1));
    // a disabled channel has no phase to protect, so the new divisor goes in at once
    assign apply = pending && (term || !en);
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            div     <= CNT_W'(DEF_DIV);
            shadow  <= CNT_W'(DEF_DIV);
            pending <= 1'b0;
            mode_q  <= MODE_SQUARE;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            cnt <= (en && !term) ? cnt + CNT_W'(1) : '0;
            if (apply) div <= shadow;
            if (load) shadow <= load_val;
            // a write landing on the apply edge stays pending for the next terminal count
            pending <= load || (pending && !apply);
            mode_q  <= mode;
            tick    <= term;
            // leaving tick mode restarts the square wave from low
            clk_out <= !en ? 1'b0 :
                       (mode == MODE_TICK) ? term :
                       (mode_q == MODE_TICK) ? 1'b0 : clk_out ^ term;
        end
    end
endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: multi-channel programmable clock divider with a single-write/ack divisor port.
// Ports: clkIn system clock; rst sync reset; en/mode per-channel enable and output mode;
// div_wr/div_ch/div_val divisor write; div_ack write acknowledge; clkOut divided clocks; tick strobes.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W = CNT_W_DEF,
    parameter int DEF_DIV = 25000000,
    localparam int CH_W = (clog2(NUM_CH) > 1) ? clog2(NUM_CH) : 1
) (
    input  logic              clkIn,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic [NUM_CH-1:0] mode,
    input  logic              div_wr,
    input  logic [CH_W-1:0]   div_ch,
    input  logic [CNT_W-1:0]  div_val,
    output logic              div_ack,
    output logic [NUM_CH-1:0] clkOut,
    output logic [NUM_CH-1:0] tick
);
    logic [CNT_W-1:0] div_fix;
    assign div_fix = (div_val == '0) ? CNT_W'(1) : div_val;
    // addresses beyond NUM_CH match no channel but are still acknowledged
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_chan #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) u_ch (
            .clk(clkIn),
            .rst(rst),
            .en(en[i]),
            .mode(mode[i]),
            .load(div_wr && (div_ch == CH_W'(i))),
            .load_val(div_fix),
            .clk_out(clkOut[i]),
            .tick(tick[i])
        );
    end
    always_ff @(posedge clkIn) begin
        if (rst) div_ack <= 1'b0;
        else div_ack <= div_wr;
    end
endmodule
